// File: rtl/tpm_product_feeder.sv
// Product feeder for the TPM hidden-unit accumulator: captures N weights/inputs on start,
// clears the accumulator, streams N signed products, then pulses done. Option: WEIGHT_CLIP_EN.
module tpm_weight_lane #(
  parameter int WW = 4,
  parameter int L  = 3
) (
  input  logic [WW-1:0] w,
  input  logic          x,
  output logic [WW:0]   prod
);
  logic signed [WW:0] wx, wc;

  // One extra bit so that negating the most negative weight cannot overflow
  assign wx = {w[WW-1], w};

`ifdef WEIGHT_CLIP_EN
  localparam logic signed [WW:0] LIM = (WW+1)'(L);

  always_comb begin
    wc = wx;
    if (wx > LIM)       wc = LIM;
    else if (wx < -LIM) wc = -LIM;
  end
`else
  assign wc = wx;
`endif

  assign prod = x ? wc : -wc;
endmodule

module tpm_product_feeder #(
  parameter int N  = 8,
  parameter int WW = 4,
  parameter int FW = 13,
  parameter int L  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*WW-1:0] w_flat,
  input  logic [N-1:0]    x_bits,
  input  logic            hold,
  output logic            acc_clr,
  output logic [FW-1:0]   feed,
  output logic            addflag,
  output logic            busy,
  output logic            done
);
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t               state, nstate;
  logic [N-1:0][WW-1:0] w_q;
  logic [N-1:0]         x_q;
  logic [IW-1:0]        idx, idx_n;
  logic [N-1:0][WW:0]   prod;
  logic [WW:0]          sel;
  logic [FW-1:0]        feed_n;
  logic                 acc_clr_n, addflag_n, done_n, busy_n, cap;

`ifndef WEIGHT_CLIP_EN
  localparam int unused_l = L;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    tpm_weight_lane #(.WW(WW), .L(L)) u_lane (
      .w    (w_q[i]),
      .x    (x_q[i]),
      .prod (prod[i])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++)
      if (idx == IW'(i)) sel = prod[i];
  end

  // Outputs are registered from the state being entered, so they line up with the state
  always_comb begin
    nstate    = state;
    idx_n     = idx;
    feed_n    = feed;
    acc_clr_n = 1'b0;
    addflag_n = 1'b0;
    done_n    = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: if (start) begin
        nstate    = CLEAR;
        cap       = 1'b1;
        idx_n     = '0;
        acc_clr_n = 1'b1;
      end
      CLEAR: begin
        nstate    = FEED;
        feed_n    = FW'($signed(sel));
        addflag_n = 1'b1;
        idx_n     = idx + 1'b1;
      end
      FEED: if (!hold) begin
        if (idx == IW'(N)) begin
          nstate = DONE;
          done_n = 1'b1;
        end else begin
          feed_n    = FW'($signed(sel));
          addflag_n = 1'b1;
          idx_n     = idx + 1'b1;
        end
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
    busy_n = (nstate != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      w_q     <= '0;
      x_q     <= '0;
      feed    <= '0;
      acc_clr <= 1'b0;
      addflag <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nstate;
      idx     <= idx_n;
      feed    <= feed_n;
      acc_clr <= acc_clr_n;
      addflag <= addflag_n;
      busy    <= busy_n;
      done    <= done_n;
      if (cap) begin
        w_q <= w_flat;
        x_q <= x_bits;
      end
    end
  end
endmodule

// File: doc/tpm_product_feeder.md
Name: tpm_product_feeder

Overview:
- Upstream stage of the hidden-unit accumulator in the neurocrypt tree parity machine.
- On start, captures one hidden unit's N weights and N input bits, and clears the accumulator.
- Then streams one signed product (weight × input, input ∈ {+1,−1}) per cycle on feed/addflag into the accumulator, and finally pulses done.

Parameters:
- N, 8, number of inputs/weights per hidden unit (2..64).
- WW, 4, weight width; weights are two's-complement.
- FW, 13, feed output width; must match the accumulator feed input.
- L, 3, synaptic depth; weight clip bound, used only with WEIGHT_CLIP_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new product sequence; sampled only in IDLE.
- w_flat  in  N*WW  weights; weight i is bits [i*WW +: WW]; captured on accepted start.
- x_bits  in  N  inputs; bit i=1 means +1, 0 means −1; captured on accepted start.
- hold  in  1  pause streaming; effective in FEED only.
- acc_clr  out  1  one-cycle pulse that clears the downstream accumulator.
- feed  out  FW  signed product, sign-extended from WW+1 bits.
- addflag  out  1  feed is valid this cycle and must be accumulated.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the accumulator holds the final sum.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - acc_clr, addflag, busy and done are 0; feed = 0.
  - Captured weight/input registers and index are 0.
  - Reset mid-sequence aborts it; no done pulse is produced.
- All outputs are registered.
- States: IDLE, CLEAR, FEED, DONE.
  - IDLE: start=1 captures w_flat and x_bits, sets idx=0, goes to CLEAR. start=0 stays in IDLE.
  - CLEAR: acc_clr=1 for exactly one cycle; then FEED.
  - FEED with hold=0: feed = x[idx] ? +w[idx] : −w[idx], addflag=1, idx increments; after idx=N−1 goes to DONE.
  - FEED with hold=1: addflag=0, feed keeps its last value, idx frozen; the product is not lost.
  - DONE: done=1 for one cycle, then IDLE. busy stays high in DONE.
- Timing with no hold: start accepted at edge k gives acc_clr at k+1, products at k+2..k+N+1, and done at k+N+2.
- start while busy is ignored; the sequence in progress is unaffected.
- Arithmetic:
  - Negation is done in WW+1 bits, so −(−2^(WW−1)) = +2^(WW−1) without overflow.
  - The result is sign-extended to FW.
  - FW ≥ WW+1 is required; the N=8, WW=4 defaults fit easily in 13 bits.
- hold has no effect in IDLE, CLEAR or DONE.
- Captured values are stable for the whole sequence; changes on w_flat/x_bits after start are ignored.

Optional Feature:
- Macro: WEIGHT_CLIP_EN.
- Defined: each captured weight is clamped to [−L, +L] before the product is formed, e.g. +7 becomes +3 and −8 becomes −3 (L=3).
- Not defined: weights are used exactly as captured; no clamp logic is generated.

Test Plan:
- Basic sequence:
  - Stimulus: weights idx0..7 = {3,−2,1,0,−3,2,−1,3}, x_bits=8'hA5, start pulse.
  - Response: acc_clr one cycle, then feed = 3,2,1,0,3,2,1,3 with addflag=1 for 8 consecutive cycles, then done.
  - The accumulator value reads 15.
- All inputs −1:
  - Stimulus: same weights, x_bits=8'h00.
  - Response: feed = −3,2,−1,0,3,−2,1,−3 (13'h1FFD for −3), accumulator reads −3 (14'h3FFD).
- Hold:
  - Stimulus: hold=1 for 3 cycles while idx=4 in the basic-sequence case.
  - Response: addflag=0 and feed stays 0 during the hold; the next product is 3 (idx 4); done arrives 3 cycles later than in the basic sequence; the sum is still 15.
- Start while busy and reset mid-sequence:
  - Stimulus: start again while busy, then rst=0 at idx=5.
  - Response: the second start is ignored; on reset all outputs go to 0 immediately, there is no done pulse, and the block returns to IDLE.
- Boundary weights:
  - Stimulus: weight −8 with x=0.
  - Response: feed=+8. With WEIGHT_CLIP_EN defined, weights +7/−8 with x=1 give feed +3/−3.
